imem_loader: RTL
================

Name: imem_loader

Overview:
- Write-side counterpart of the 17-bit instruction memory: receives a framed byte stream (from a UART/host link) and writes 17-bit instructions into instruction memory, starting at address 0.
- Holds the processor off via busy while loading.
- Sits between the serial receiver and the instruction-memory write port.

Parameters:
- DEPTH, 2048, number of instruction words in memory; highest legal word count.
- ADDR_W, 16, width of im_waddr.
- SYNC_BYTE, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  incoming byte
- rx_vld  in  1  rx_data valid
- rx_rdy  out  1  loader can accept a byte; transfer = rx_vld & rx_rdy
- im_we  out  1  one-cycle instruction-memory write strobe
- im_waddr  out  ADDR_W  write address
- im_wdata  out  17  instruction word
- busy  out  1  load in progress; processor must stay stalled/in reset
- done  out  1  sticky: last frame loaded successfully
- err  out  1  sticky: last frame aborted

Behaviour:
- Reset values: rx_rdy=0, im_we=0, im_waddr=0, im_wdata=0, busy=0, done=0, err=0, state=IDLE. Reset mid-frame aborts with no further writes.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO (16-bit word count N), then N x 3 bytes per word.
  - Byte B0: bits[7:1] must be 0, bit0 = instr[16].
  - Byte B1 = instr[15:8].
  - Byte B2 = instr[7:0].
- rx_rdy=1 in IDLE, LEN_HI, LEN_LO, B0, B1, B2, DONE and ERR. rx_rdy=0 in WRITE.
- States and transitions:
  - IDLE: accepted byte == SYNC_BYTE -> LEN_HI, busy=1. Any other byte is discarded; stay in IDLE.
  - LEN_HI: store count[15:8] -> LEN_LO.
  - LEN_LO: store count[7:0].
    - N==0 or N>DEPTH -> ERR.
    - Otherwise -> B0, with word counter=0 and im_waddr=0.
  - B0: bits[7:1]!=0 -> ERR. Otherwise latch bit16 -> B1.
  - B1: latch [15:8] -> B2.
  - B2: latch [7:0] -> WRITE.
  - WRITE: im_we=1 for exactly one cycle with im_waddr=counter and im_wdata=assembled word.
    - Next cycle: counter+1 and im_waddr+1.
    - If counter+1==N -> DONE (or CHK with the optional feature); else -> B0.
  - DONE: busy=0, done=1.
  - ERR: busy=0, err=1.
  - From DONE or ERR, an accepted SYNC_BYTE clears done and err, sets busy=1 -> LEN_HI. Other bytes are discarded.
- SYNC_BYTE inside a frame is treated as data; there is no resync.
- Latency: the write strobe occurs on the cycle after the B2 byte is accepted.
- Timing: worst-case byte throughput is 1 per cycle except for the single WRITE bubble.
- Address arithmetic: im_waddr never exceeds DEPTH-1; there is no wrap, because N<=DEPTH is enforced.
- Partial frames: words written before an error remain in memory; err tells software to reload.
- Outputs are registered. im_wdata holds its last value when im_we=0.

Optional Feature:
- Macro: IMEM_LOADER_CHKSUM_EN.
- Defined:
  - After the last WRITE, state CHK accepts one byte.
  - The byte must equal the XOR of all B0/B1/B2 data bytes of the frame (accumulator cleared in LEN_LO).
  - Equal -> DONE. Mismatch -> ERR. Words are already written.
- Undefined: no CHK state and no accumulator; last WRITE -> DONE directly.

Decomposition:
- Shared package imem_pkg:
  - state enum typedef (IDLE, LEN_HI, LEN_LO, B0, B1, B2, WRITE, CHK, DONE, ERR).
  - INSTR_W=17 and IMEM_DEPTH=2048 constants.
  - SYNC_BYTE default.
- One sub-module is natural: imem_loader_asm, the 3-byte-to-17-bit word assembler with B0 format check and XOR accumulator.
- The FSM and counters stay in the top.

Test Plan:
- Load: A5 00 02 | 01 23 45 | 00 BE EF -> im_we pulses twice: addr0=17'h12345, addr1=17'h0BEEF; done=1, busy=0, err=0.
- Length 0 (A5 00 00) -> err=1, no im_we. Length 0x0801 -> err=1, no im_we.
- Bad B0: A5 00 01 | 02 .. -> err=1 after B0 accepted, no write. Then a fresh valid frame -> err clears, done=1.
- Backpressure/gaps: random rx_vld gaps and a full 2048-word load -> last write addr 2047, correct data, rx_rdy low only in WRITE cycles.
- Reset asserted after 5 of 10 words -> all outputs reset immediately, no further im_we; a following frame loads from addr 0.
- With IMEM_LOADER_CHKSUM_EN: frame of word 17'h12345 plus checksum 0x67 (01^23^45) -> done=1. Checksum 0x66 -> err=1.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory loader
package imem_pkg;

  localparam int INSTR_W = 17;
  localparam int IMEM_DEPTH = 2048;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/imem_loader_asm.sv
// rtl/imem_loader_asm.sv - 3-byte to 17-bit word assembler with B0 format check
// IMEM_LOADER_CHKSUM_EN adds the frame XOR accumulator.
module imem_loader_asm
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_byte,
  input  logic               ld_b0,
  input  logic               ld_b1,
`ifdef IMEM_LOADER_CHKSUM_EN
  input  logic               acc_clr,
  input  logic               acc_en,
  output logic               chk_ok,
`endif
  output logic               b0_ok,
  output logic [INSTR_W-1:0] word
);

  logic       bit16_q;
  logic [7:0] hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit16_q <= 1'b0;
      hi_q    <= 8'h00;
    end else begin
      if (ld_b0) bit16_q <= rx_byte[0];
      if (ld_b1) hi_q    <= rx_byte;
    end
  end

  assign b0_ok = (rx_byte[7:1] == 7'd0);
  // Low byte comes straight from the wire so the top can register the word on the B2 accept.
  assign word  = {bit16_q, hi_q, rx_byte};

`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0] acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= 8'h00;
    end else if (acc_clr) begin
      acc_q <= 8'h00;
    end else if (acc_en) begin
      acc_q <= acc_q ^ rx_byte;
    end
  end

  assign chk_ok = (rx_byte == acc_q);
`endif

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to 17-bit instruction-memory writer
// IMEM_LOADER_CHKSUM_EN enables a trailing XOR checksum byte per frame.
module imem_loader
  import imem_pkg::*;
#(
  parameter int         DEPTH     = IMEM_DEPTH,
  parameter int         ADDR_W    = 16,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_vld,
  output logic               rx_rdy,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_waddr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t state, state_next;

  logic [7:0]         len_hi;
  logic [15:0]        word_total;
  logic [15:0]        word_cnt;
  logic               xfer;
  logic               last_word;
  logic               len_bad;
  logic               b0_ok;
  logic [INSTR_W-1:0] asm_word;
  logic               chk_ok;

  assign xfer      = rx_vld & rx_rdy;
  assign last_word = ((word_cnt + 16'd1) == word_total);
  assign len_bad   = ({len_hi, rx_data} == 16'd0) || ({1'b0, len_hi, rx_data} > DEPTH_L);

  imem_loader_asm u_asm (
    .clk     (clk),
    .rst     (rst),
    .rx_byte (rx_data),
    .ld_b0   (xfer && state == ST_B0),
    .ld_b1   (xfer && state == ST_B1),
`ifdef IMEM_LOADER_CHKSUM_EN
    .acc_clr (xfer && state == ST_LEN_LO),
    .acc_en  (xfer && (state == ST_B0 || state == ST_B1 || state == ST_B2)),
    .chk_ok  (chk_ok),
`endif
    .b0_ok   (b0_ok),
    .word    (asm_word)
  );

`ifndef IMEM_LOADER_CHKSUM_EN
  assign chk_ok = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (xfer && rx_data == SYNC_BYTE) state_next = ST_LEN_HI;
      ST_LEN_HI: if (xfer) state_next = ST_LEN_LO;
      ST_LEN_LO: if (xfer) state_next = len_bad ? ST_ERR : ST_B0;
      ST_B0:     if (xfer) state_next = b0_ok ? ST_B1 : ST_ERR;
      ST_B1:     if (xfer) state_next = ST_B2;
      ST_B2:     if (xfer) state_next = ST_WRITE;
`ifdef IMEM_LOADER_CHKSUM_EN
      ST_WRITE:  state_next = last_word ? ST_CHK : ST_B0;
      ST_CHK:    if (xfer) state_next = chk_ok ? ST_DONE : ST_ERR;
`else
      ST_WRITE:  state_next = last_word ? ST_DONE : ST_B0;
`endif
      ST_DONE,
      ST_ERR:    if (xfer && rx_data == SYNC_BYTE) state_next = ST_LEN_HI;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered decodes of the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_rdy     <= 1'b0;
      im_we      <= 1'b0;
      im_waddr   <= '0;
      im_wdata   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      len_hi     <= 8'h00;
      word_total <= 16'd0;
      word_cnt   <= 16'd0;
    end else begin
      rx_rdy <= (state_next != ST_WRITE);
      im_we  <= (state_next == ST_WRITE);
      busy   <= !(state_next inside {ST_IDLE, ST_DONE, ST_ERR});
      done   <= (state_next == ST_DONE);
      err    <= (state_next == ST_ERR);

      if (xfer && state == ST_LEN_HI) len_hi <= rx_data;
      if (xfer && state == ST_LEN_LO) begin
        word_total <= {len_hi, rx_data};
        word_cnt   <= 16'd0;
        im_waddr   <= '0;
      end
      if (xfer && state == ST_B2) im_wdata <= asm_word;
      // Address stops on the last word so it never reaches DEPTH.
      if (state == ST_WRITE) begin
        word_cnt <= word_cnt + 16'd1;
        if (!last_word) im_waddr <= im_waddr + ADDR_W'(1);
      end
    end
  end

endmodule
